// File: rtl/mnist_test_sequencer_if.sv
// Bundle of signals between the MNIST test sequencer and its surroundings:
// pattern ROM, inference core, control pulses and status/result outputs.
//   start, step             : control pulses into the sequencer
//   mem_addr / mem_data     : {image, byte} ROM address out, ROM data back (1-cycle latency)
//   core_data               : registered byte streamed to the inference core
//   core_index, core_value  : live core outputs
//   result_index/value/valid: latched core result and one-cycle latch pulse
//   expected_digit, image_idx, busy, pass, fail : test progress and verdict
// Modports: slave = sequencer side, master = system/testbench side.
interface mnist_test_sequencer_if #(
  parameter int IMAGE_COUNT     = 480,
  parameter int BYTES_PER_IMAGE = 32
) ();
  localparam int AW = $clog2(IMAGE_COUNT * BYTES_PER_IMAGE);
  localparam int IW = $clog2(IMAGE_COUNT);

  logic          start;
  logic          step;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic [7:0]    core_data;
  logic [3:0]    core_index;
  logic [7:0]    core_value;
  logic [3:0]    result_index;
  logic [7:0]    result_value;
  logic          result_valid;
  logic [3:0]    expected_digit;
  logic [IW-1:0] image_idx;
  logic          busy;
  logic          pass;
  logic          fail;

  modport slave (
    input  start, step, mem_data, core_index, core_value,
    output mem_addr, core_data, result_index, result_value, result_valid,
           expected_digit, image_idx, busy, pass, fail
  );

  modport master (
    output start, step, mem_data, core_index, core_value,
    input  mem_addr, core_data, result_index, result_value, result_valid,
           expected_digit, image_idx, busy, pass, fail
  );
endinterface

// File: rtl/mnist_test_sequencer.sv
// MNIST test sequencer: streams each stored test image from the pattern ROM
// to the inference core, latches the core's answer after a warm-up period,
// and on each step tick compares it with the expected digit (0..9 cycling).
// A mismatch stops the pass with fail; matching every image gives pass.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mnist_test_sequencer_if.slave (see interface for signal list)
module mnist_test_sequencer #(
  parameter int IMAGE_COUNT     = 480,
  parameter int BYTES_PER_IMAGE = 32,
  parameter int LATCH_OFFSET    = 1,
  parameter int WARMUP_FRAMES   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mnist_test_sequencer_if.slave  bus
);
  localparam int BW = $clog2(BYTES_PER_IMAGE);
  localparam int IW = $clog2(IMAGE_COUNT);
  localparam int FW = $clog2(WARMUP_FRAMES + 1) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_HOLD,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t        state_q,     state_d;
  logic [BW-1:0] byte_cnt_q,  byte_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [IW-1:0] image_idx_q, image_idx_d;
  logic [3:0]    digit_q,     digit_d;
  logic [7:0]    core_data_q, core_data_d;
  logic [3:0]    res_idx_q,   res_idx_d;
  logic [7:0]    res_val_q,   res_val_d;
  logic          res_vld_q,   res_vld_d;
  logic          pass_q,      pass_d;
  logic          fail_q,      fail_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      frame_cnt_q <= '0;
      image_idx_q <= '0;
      digit_q     <= '0;
      core_data_q <= '0;
      res_idx_q   <= '0;
      res_val_q   <= '0;
      res_vld_q   <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      image_idx_q <= image_idx_d;
      digit_q     <= digit_d;
      core_data_q <= core_data_d;
      res_idx_q   <= res_idx_d;
      res_val_q   <= res_val_d;
      res_vld_q   <= res_vld_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    // byte counter free-runs in every state so frame alignment never shifts
    byte_cnt_d  = byte_cnt_q + 1'b1;
    frame_cnt_d = frame_cnt_q;
    image_idx_d = image_idx_q;
    digit_d     = digit_q;
    core_data_d = bus.mem_data;
    res_idx_d   = res_idx_q;
    res_val_d   = res_val_q;
    res_vld_d   = 1'b0;
    pass_d      = pass_q;
    fail_d      = fail_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.start) begin
          state_d     = ST_STREAM;
          image_idx_d = '0;
          digit_d     = '0;
          frame_cnt_d = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
        end
      end
      ST_STREAM: begin
        if (frame_cnt_q == FW'(WARMUP_FRAMES) && byte_cnt_q == BW'(LATCH_OFFSET)) begin
          res_idx_d = bus.core_index;
          res_val_d = bus.core_value;
          res_vld_d = 1'b1;
          state_d   = ST_HOLD;
        end else if (byte_cnt_q == '1) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.step) begin
          if (res_idx_q != digit_q) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else if (image_idx_q == IW'(IMAGE_COUNT - 1)) begin
            state_d     = ST_DONE;
            pass_d      = 1'b1;
            image_idx_d = '0;
            digit_d     = '0;
          end else begin
            state_d     = ST_STREAM;
            image_idx_d = image_idx_q + 1'b1;
            digit_d     = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            frame_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_addr       = {image_idx_q, byte_cnt_q};
  assign bus.core_data      = core_data_q;
  assign bus.result_index   = res_idx_q;
  assign bus.result_value   = res_val_q;
  assign bus.result_valid   = res_vld_q;
  assign bus.expected_digit = digit_q;
  assign bus.image_idx      = image_idx_q;
  assign bus.busy           = (state_q == ST_STREAM) || (state_q == ST_HOLD);
  assign bus.pass           = pass_q;
  assign bus.fail           = fail_q;
endmodule

// File: doc/mnist_test_sequencer.md
MNIST_TEST_SEQUENCER -- requirements
Module: mnist_test_sequencer

Interface
REQ-001 SHALL have parameter IMAGE_COUNT, default 480, number of stored test images.
REQ-002 SHALL have parameter BYTES_PER_IMAGE, default 32, power of two, bytes per image frame.
REQ-003 SHALL have parameter LATCH_OFFSET, default 1, byte index within a frame at which the core result is latched.
REQ-004 SHALL have parameter WARMUP_FRAMES, default 2, full frames streamed before the first latch of each image.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, pulse that begins a test pass.
REQ-008 SHALL have port step, input, 1, single-cycle timer tick that commits the current result and advances.
REQ-009 SHALL have port mem_addr, output, AW = clog2(IMAGE_COUNT*BYTES_PER_IMAGE), {image, byte} pattern ROM address.
REQ-010 SHALL have port mem_data, input, 8, ROM data with one-cycle read latency.
REQ-011 SHALL have port core_data, output, 8, registered byte driven to the inference core.
REQ-012 SHALL have port core_index, input, 4; and port core_value, input, 8, the core's live outputs.
REQ-013 SHALL have ports result_index, output, 4; result_value, output, 8; result_valid, output, 1, latched result and a one-cycle latch pulse.
REQ-014 SHALL have ports expected_digit, output, 4; image_idx, output, IW = clog2(IMAGE_COUNT); busy, pass, fail, outputs, 1.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM, HOLD, DONE, FAIL.
REQ-016 SHALL drive mem_addr = {image_idx, byte_cnt} in every state; byte_cnt is log2(BYTES_PER_IMAGE) bits, increments every cycle, and wraps to 0.
REQ-017 SHALL register mem_data into core_data every cycle, so core_data lags mem_addr by 2 cycles.
REQ-018 SHALL, in IDLE, go to STREAM on start, clearing image_idx, expected_digit, frame_cnt, pass, and fail.
REQ-019 SHALL, in STREAM, increment frame_cnt on each byte_cnt wrap to 0.
REQ-020 SHALL, in STREAM, when frame_cnt == WARMUP_FRAMES and byte_cnt == LATCH_OFFSET, capture core_index and core_value into result_index and result_value, pulse result_valid, and enter HOLD.
REQ-021 SHALL, in HOLD, keep streaming the same image and ignore start.
REQ-022 SHALL, on step in HOLD with result_index != expected_digit, enter FAIL and set fail = 1.
REQ-023 SHALL, on step in HOLD with a match, set expected_digit to (expected_digit == 9) ? 0 : expected_digit + 1 and increment image_idx.
REQ-024 SHALL, on a matching step with image_idx == IMAGE_COUNT-1, instead enter DONE, set pass = 1, and reset image_idx and expected_digit to 0.
REQ-025 SHALL, on a matching step that is not the last image, clear frame_cnt and re-enter STREAM.
REQ-026 SHALL ignore step in IDLE, STREAM, DONE, and FAIL, including a step coincident with the latch cycle.
REQ-027 SHALL ignore start in STREAM and HOLD.
REQ-028 SHALL treat start in DONE or FAIL as in IDLE, per REQ-018.
REQ-029 SHALL hold fail and pass sticky until start or rst, and SHALL never assert both.
REQ-030 SHALL assert busy only in STREAM and HOLD.
REQ-031 SHALL keep byte_cnt free-running across all state transitions, so frame alignment is never disturbed.
REQ-032 SHALL keep result_index and result_value unchanged except on latch.

Reset
REQ-033 SHALL, on rst asserted at any time (including mid-frame), immediately set state = IDLE and all counters, result_index, result_value, core_data, expected_digit, and image_idx to 0.
REQ-034 SHALL, on rst, set result_valid, busy, pass, and fail to 0.
REQ-035 SHALL, on rst, drive mem_addr = 0.
REQ-036 SHALL resume on the first clk edge after rst deasserts, with byte_cnt starting at 0.

Verification
REQ-037 Reset then start; ROM byte k of image 0 = k: core_data shows 0,1,2... starting 3 cycles after start, wrapping 31->0; result_valid is first asserted at cycle 2*32+1 after start.
REQ-038 Core model returns index = image_idx mod 10 (IMAGE_COUNT = 12) with a step after each latch: 12 matches; pass = 1, state DONE, expected_digit = 0, image_idx = 0; expected_digit sequence 0..9,0,1.
REQ-039 Core returns 7 when 3 is expected (image 3): fail = 1 on that step; image_idx stays 3; later steps are ignored; start clears fail and restarts at image 0.
REQ-040 step pulses during STREAM and start pulses during HOLD produce no state, counter, or flag change; the step after the latch is honoured.
REQ-041 rst asserted for 1 cycle mid-HOLD at image 5: all outputs are 0 asynchronously; IDLE is held until start.
REQ-042 IMAGE_COUNT = 480: image_idx reaches 479 and mem_addr reaches 15359 (14-bit) with no overflow; pass is asserted after the 480th match.
